// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: sequencer state type, default parameters and output decode shared by reset_sequencer.
package reset_seq_pkg;
    typedef enum logic [1:0] {HOLD, EXT_RST, SETTLE, RUN} rst_state_t;
    localparam int DEF_SYNC_STAGES     = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1024;
    localparam int DEF_EXT_RST_CYCLES  = 250;
    localparam int DEF_SETTLE_CYCLES   = 2500;
    // {ext_rst, reset_cpu, seq_done} for a state
    function automatic logic [2:0] decode_outputs(input rst_state_t s);
        return {s == HOLD || s == EXT_RST, s != RUN, s == RUN};
    endfunction
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: multi-flop synchronizer followed by a mismatch-count debouncer.
// DEBOUNCE_CYCLES == 1 degenerates to a plain synchronizer.
module sync_debounce #(
    parameter int SYNC_STAGES     = 3,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_stable
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    assign w_sync = r_sync[SYNC_STAGES-1];
    generate
        if (DEBOUNCE_CYCLES == 1) begin : g_plain
            assign o_stable = w_sync;
        end else begin : g_deb
            localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
            logic [DW-1:0] r_cnt;
            logic          r_stable;
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    r_cnt    <= '0;
                    r_stable <= 1'b0;
                end else if (w_sync == r_stable) begin
                    r_cnt    <= '0;
                end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable <= w_sync;
                    r_cnt    <= '0;
                end else begin
                    r_cnt    <= r_cnt + 1'b1;
                end
            assign o_stable = r_stable;
        end
    endgenerate
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset HOLD -> EXT_RST -> SETTLE -> RUN from nreset, PLL lock and DTR.
// Define RESET_DTR_EN to let a debounced DTR rising edge restart the sequence.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int EXT_RST_CYCLES  = DEF_EXT_RST_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES
) (
    input  logic clk,
    input  logic nreset,
    input  logic pll_locked,
    input  logic dtr,
    output logic dtr_stable,
    output logic ext_rst,
    output logic ext_nrst,
    output logic reset_cpu,
    output logic seq_done
);
    localparam int MAXC = (EXT_RST_CYCLES > SETTLE_CYCLES) ? EXT_RST_CYCLES : SETTLE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    logic [SYNC_STAGES-1:0] r_rst_sync;
    logic                   w_rst_n_s, w_pll_locked_s, w_dtr_rise;
    rst_state_t             r_state, w_next;
    logic [CW-1:0]          r_cnt, w_cnt_next;
    logic [2:0]             w_dec;
    logic                   r_ext_rst, r_ext_nrst, r_reset_cpu, r_seq_done;
    // async assert, synchronous release
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) r_rst_sync <= '0;
        else         r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
    assign w_rst_n_s = r_rst_sync[SYNC_STAGES-1];
    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(1)) u_pll_sync (
        .clk      (clk),
        .rst_n    (nreset),
        .i_async  (pll_locked),
        .o_stable (w_pll_locked_s)
    );
    sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dtr_deb (
        .clk      (clk),
        .rst_n    (nreset),
        .i_async  (dtr),
        .o_stable (dtr_stable)
    );
`ifdef RESET_DTR_EN
    logic r_dtr_prev;
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) r_dtr_prev <= 1'b0;
        else         r_dtr_prev <= dtr_stable;
    assign w_dtr_rise = dtr_stable & ~r_dtr_prev;
`else
    assign w_dtr_rise = 1'b0;
`endif
    // lock loss beats a DTR restart, which beats normal sequencing
    always_comb begin
        w_next     = r_state;
        w_cnt_next = '0;
        if (!w_pll_locked_s) w_next = HOLD;
        else if (w_dtr_rise && r_state != HOLD) w_next = EXT_RST;
        else
            case (r_state)
                HOLD:    w_next = w_rst_n_s ? EXT_RST : HOLD;
                EXT_RST: begin
                    w_next     = (r_cnt == CW'(EXT_RST_CYCLES - 1)) ? SETTLE : EXT_RST;
                    w_cnt_next = (r_cnt == CW'(EXT_RST_CYCLES - 1)) ? '0 : r_cnt + 1'b1;
                end
                SETTLE:  begin
                    w_next     = (r_cnt == CW'(SETTLE_CYCLES - 1)) ? RUN : SETTLE;
                    w_cnt_next = (r_cnt == CW'(SETTLE_CYCLES - 1)) ? '0 : r_cnt + 1'b1;
                end
                default: w_next = RUN;
            endcase
    end
    assign w_dec = decode_outputs(w_next);
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            r_state     <= HOLD;
            r_cnt       <= '0;
            r_ext_rst   <= 1'b1;
            r_ext_nrst  <= 1'b0;
            r_reset_cpu <= 1'b1;
            r_seq_done  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_ext_rst   <= w_dec[2];
            r_ext_nrst  <= ~w_dec[2];
            r_reset_cpu <= w_dec[1];
            r_seq_done  <= w_dec[0];
        end
    assign ext_rst   = r_ext_rst;
    assign ext_nrst  = r_ext_nrst;
    assign reset_cpu = r_reset_cpu;
    assign seq_done  = r_seq_done;
endmodule
